// File: rtl/rsc_dec_pkg.sv
// Shared types and constants for the RSC turbo decoder address-control path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rsc_dec_pkg;

    localparam int cRSC_W      = 13;
    localparam int cRSC_ITER_W = 5;

    // Half-iteration sequencer states
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/rsc_dec_addr_ctrl.sv
// Half-iteration sequencer driving clear/enable/pmode of the fwd/bwd address generators.
// Latency: istart -> obusy 1 cycle, oclear 2 cycles, first oenable 3 cycles; 2+N+pDELAY cycles per half.
// Backpressure: none from downstream; iclkena low freezes all state and outputs in place.
//
// Ports:
//   iclk, ireset (sync, active-high), iclkena   clock / reset / clock enable
//   istart, iN, iNiter                          decode request; iN and iNiter latched on start only
//   oclear, oenable, opmode                     address generator controls (opmode: 0 direct, 1 permuted)
//   osof, oeof                                  first / last enable cycle of a half-iteration
//   ohalf                                       current half-iteration index
//   obusy, odone                                not-IDLE flag / one-cycle completion pulse
module rsc_dec_addr_ctrl
    import rsc_dec_pkg::*;
#(
    parameter int pW      = cRSC_W,
    parameter int pITER_W = cRSC_ITER_W,
    parameter int pDELAY  = 8
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               istart,
    input  logic [pW-1:0]      iN,
    input  logic [pITER_W-1:0] iNiter,
    output logic               oclear,
    output logic               oenable,
    output logic               opmode,
    output logic               osof,
    output logic               oeof,
    output logic [pITER_W:0]   ohalf,
    output logic               obusy,
    output logic               odone
);

    // Drain counter needs at least one bit even when the drain gap is disabled.
    localparam int cDW = (pDELAY > 0) ? $clog2(pDELAY + 1) : 1;
    localparam logic [cDW-1:0] cDLOAD = cDW'((pDELAY > 0) ? pDELAY - 1 : 0);

    ctrl_state_t          state_q, state_d;
    logic [pW-1:0]        n_q, n_d;
    logic [pITER_W:0]     hlast_q, hlast_d;
    logic [pW-1:0]        cnt_q, cnt_d;
    logic [cDW-1:0]       dcnt_q, dcnt_d;
    logic [pITER_W:0]     half_q, half_d;

    logic [pITER_W-1:0]   iter_eff;
    logic [pW-1:0]        n_m1;
    logic                 last_half;

    // A zero iteration count runs a single iteration.
    assign iter_eff  = (iNiter == '0) ? pITER_W'(1) : iNiter;
    assign n_m1      = n_q - 1'b1;
    assign last_half = (half_q == hlast_q);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        hlast_d = hlast_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        half_d  = half_q;

        unique case (state_q)
            IDLE: begin
                if (istart) begin
                    n_d     = iN;
                    hlast_d = {iter_eff, 1'b0} - 1'b1;
                    half_d  = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d   = n_m1;
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == '0) begin
                    if (pDELAY > 0) begin
                        dcnt_d  = cDLOAD;
                        state_d = DRAIN;
                    end else begin
                        // No drain gap: close the half-iteration straight from RUN.
                        state_d = last_half ? DONE : INIT;
                        if (!last_half) begin
                            half_d = half_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt_q == '0) begin
                    state_d = last_half ? DONE : INIT;
                    if (!last_half) begin
                        half_d = half_q + 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q <= IDLE;
            n_q     <= '0;
            hlast_q <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            half_q  <= '0;
        end else if (iclkena) begin
            state_q <= state_d;
            n_q     <= n_d;
            hlast_q <= hlast_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            half_q  <= half_d;
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        oclear  = (state_q == CLEAR);
        oenable = (state_q == RUN);
        // pmode is presented from CLEAR onward so both generators see it stable for the whole pass.
        opmode  = ((state_q == CLEAR) || (state_q == RUN) || (state_q == DRAIN)) && half_q[0];
        osof    = (state_q == RUN) && (cnt_q == n_m1);
        oeof    = (state_q == RUN) && (cnt_q == '0);
        ohalf   = half_q;
        obusy   = (state_q != IDLE);
        odone   = (state_q == DONE);
    end

endmodule
